// File: rtl/mr_pkg.sv
// Shared encodings for the Maquina Rudimentaria control unit: FSM states,
// instruction classes, ALU function/op codes, PC select and branch conditions.
package mr_pkg;

    typedef enum logic [2:0] {
        S_RESET_PC = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_LD_MEM   = 3'd4,
        S_ST_MEM   = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [1:0] CL_LOAD   = 2'b00;
    localparam logic [1:0] CL_STORE  = 2'b01;
    localparam logic [1:0] CL_BRANCH = 2'b10;
    localparam logic [1:0] CL_ALU    = 2'b11;

    localparam logic [2:0] F_ADDI = 3'b000;
    localparam logic [2:0] F_SUBI = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b100;
    localparam logic [2:0] F_SUB  = 3'b101;
    localparam logic [2:0] F_ASR  = 3'b110;
    localparam logic [2:0] F_AND  = 3'b111;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_ZERO = 2'b10;

    localparam logic [2:0] BR_ALWAYS = 3'b000;
    localparam logic [2:0] BR_Z      = 3'b001;
    localparam logic [2:0] BR_N      = 3'b010;
    localparam logic [2:0] BR_NZ     = 3'b011;
    localparam logic [2:0] BR_NEVER  = 3'b100;
    localparam logic [2:0] BR_NOT_Z  = 3'b101;
    localparam logic [2:0] BR_NOT_N  = 3'b110;
    localparam logic [2:0] BR_GT     = 3'b111;

    typedef struct packed {
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_rdir;
        logic       ld_ra;
        logic       ld_regb;
        logic [1:0] pc_sel;
        logic       addr_sel;
        logic [2:0] regb_addr_r;
        logic [2:0] regb_addr_w;
        logic       operar;
        logic [1:0] alu_op;
        logic       alu_imm;
        logic       mem_rd;
        logic       mem_wr;
        logic       halt;
    } ctrl_t;

    // Returns {legal, alu_imm, alu_op[1:0]} for an ALU function field
    function automatic logic [3:0] alu_decode(input logic [2:0] func);
        logic [3:0] res;
        case (func)
            F_ADDI:  res = {1'b1, 1'b1, OP_ADD};
            F_SUBI:  res = {1'b1, 1'b1, OP_SUB};
            F_ADD:   res = {1'b1, 1'b0, OP_ADD};
            F_SUB:   res = {1'b1, 1'b0, OP_SUB};
            F_ASR:   res = {1'b1, 1'b0, OP_ASR};
            F_AND:   res = {1'b1, 1'b0, OP_AND};
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mr_branch_eval.sv
// Branch condition evaluator: decides whether a BRANCH is taken from the
// condition field and the latched Z/N flags.
module mr_branch_eval
    import mr_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    output logic       taken
);

    // Condition truth table; code 100 is the never-taken NOP
    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_ALWAYS: taken = 1'b1;
            BR_Z:      taken = z;
            BR_N:      taken = n;
            BR_NZ:     taken = n | z;
            BR_NEVER:  taken = 1'b0;
            BR_NOT_Z:  taken = ~z;
            BR_NOT_N:  taken = ~n;
            BR_GT:     taken = ~n & ~z;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mr_control_unit.sv
// Maquina Rudimentaria control unit: fetch/decode/execute sequencer with memory
// handshake and ack timeout. Optional MR_CU_SINGLE_STEP_EN adds a step input.
module mr_control_unit
    import mr_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int TW          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MR_CU_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] ir,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        mem_ack,
    output logic        ld_ir,
    output logic        ld_pc,
    output logic        ld_rdir,
    output logic        ld_ra,
    output logic        ld_regb,
    output logic [1:0]  pc_sel,
    output logic        addr_sel,
    output logic [2:0]  regb_addr_r,
    output logic [2:0]  regb_addr_w,
    output logic        operar,
    output logic [1:0]  alu_op,
    output logic        alu_imm,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        halt
);

    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    state_t         state_r, state_s;
    ctrl_t          ctrl_s, ctrl_out_s;
    logic [TW-1:0]  cnt_r;
    logic           z_r, n_r;
    logic           taken_s, go_s, timeout_s;
    logic [3:0]     alu_dec_s;
    logic           unused_s;

    assign unused_s  = ^ir[4:3];
    assign alu_dec_s = alu_decode(ir[2:0]);
    assign timeout_s = (ACK_TIMEOUT != 0) && (cnt_r == TO_LAST);

    mr_branch_eval u_branch_eval (
        .cond  (ir[13:11]),
        .z     (z_r),
        .n     (n_r),
        .taken (taken_s)
    );

`ifdef MR_CU_SINGLE_STEP_EN
    logic step_pend_r;
    assign go_s = step_pend_r;

    // Step pulses are remembered until the next FETCH completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pend_r <= 1'b0;
        end else begin
            step_pend_r <= (step_pend_r & ~((state_r == S_FETCH) & mem_ack)) | step;
        end
    end
`else
    assign go_s = 1'b1;
`endif

    // Next-state and control decode
    always_comb begin
        state_s = state_r;
        ctrl_s  = '0;
        case (state_r)
            S_RESET_PC: begin
                ctrl_s.pc_sel = PC_ZERO;
                ctrl_s.ld_pc  = 1'b1;
                state_s       = S_FETCH;
            end
            S_FETCH: begin
                if (go_s) begin
                    ctrl_s.mem_rd = 1'b1;
                    if (mem_ack) begin
                        ctrl_s.ld_ir  = 1'b1;
                        ctrl_s.ld_pc  = 1'b1;
                        ctrl_s.pc_sel = PC_INC;
                        state_s       = S_DECODE;
                    end else if (timeout_s) begin
                        state_s = S_HALT;
                    end else begin
                        state_s = S_FETCH;
                    end
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                ctrl_s.ld_rdir     = 1'b1;
                ctrl_s.ld_ra       = 1'b1;
                ctrl_s.regb_addr_r = ir[10:8];
                case (ir[15:14])
                    CL_LOAD:  state_s = S_LD_MEM;
                    CL_STORE: state_s = S_ST_MEM;
                    CL_ALU:   state_s = alu_dec_s[3] ? S_EXEC : S_HALT;
                    CL_BRANCH: begin
                        ctrl_s.ld_pc  = taken_s;
                        ctrl_s.pc_sel = taken_s ? PC_BR : PC_INC;
                        state_s       = S_FETCH;
                    end
                    default:  state_s = S_HALT;
                endcase
            end
            S_EXEC: begin
                ctrl_s.operar      = 1'b1;
                ctrl_s.alu_op      = alu_dec_s[1:0];
                ctrl_s.alu_imm     = alu_dec_s[2];
                ctrl_s.regb_addr_r = ir[7:5];
                ctrl_s.regb_addr_w = ir[13:11];
                ctrl_s.ld_regb     = 1'b1;
                state_s            = S_FETCH;
            end
            S_LD_MEM: begin
                ctrl_s.addr_sel = 1'b1;
                ctrl_s.mem_rd   = 1'b1;
                if (mem_ack) begin
                    ctrl_s.regb_addr_w = ir[13:11];
                    ctrl_s.ld_regb     = 1'b1;
                    state_s            = S_FETCH;
                end else if (timeout_s) begin
                    state_s = S_HALT;
                end else begin
                    state_s = S_LD_MEM;
                end
            end
            S_ST_MEM: begin
                ctrl_s.addr_sel    = 1'b1;
                ctrl_s.regb_addr_r = ir[13:11];
                ctrl_s.mem_wr      = 1'b1;
                if (mem_ack) begin
                    state_s = S_FETCH;
                end else if (timeout_s) begin
                    state_s = S_HALT;
                end else begin
                    state_s = S_ST_MEM;
                end
            end
            S_HALT: begin
                ctrl_s.halt = 1'b1;
                state_s     = S_HALT;
            end
            default: begin
                ctrl_s.halt = 1'b1;
                state_s     = S_HALT;
            end
        endcase
    end

    // State, wait counter and Z/N flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RESET_PC;
            cnt_r   <= '0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r <= '0;
            end else if (ctrl_s.mem_rd | ctrl_s.mem_wr) begin
                cnt_r <= cnt_r + TW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (ctrl_s.ld_regb) begin
                z_r <= alu_z;
                n_r <= alu_n;
            end else begin
                z_r <= z_r;
                n_r <= n_r;
            end
        end
    end

    // Outputs are forced low for as long as reset is held
    always_comb begin
        if (rst_n) begin
            ctrl_out_s = ctrl_s;
        end else begin
            ctrl_out_s = '0;
        end
    end

    assign ld_ir       = ctrl_out_s.ld_ir;
    assign ld_pc       = ctrl_out_s.ld_pc;
    assign ld_rdir     = ctrl_out_s.ld_rdir;
    assign ld_ra       = ctrl_out_s.ld_ra;
    assign ld_regb     = ctrl_out_s.ld_regb;
    assign pc_sel      = ctrl_out_s.pc_sel;
    assign addr_sel    = ctrl_out_s.addr_sel;
    assign regb_addr_r = ctrl_out_s.regb_addr_r;
    assign regb_addr_w = ctrl_out_s.regb_addr_w;
    assign operar      = ctrl_out_s.operar;
    assign alu_op      = ctrl_out_s.alu_op;
    assign alu_imm     = ctrl_out_s.alu_imm;
    assign mem_rd      = ctrl_out_s.mem_rd;
    assign mem_wr      = ctrl_out_s.mem_wr;
    assign halt        = ctrl_out_s.halt;

endmodule

// File: doc/mr_control_unit.md
Name: mr_control_unit

Overview:
Control unit for the Maquina Rudimentaria datapath. It decodes the 16-bit instruction held in IR and sequences fetch, decode and execute. It drives every datapath load, select and ALU control, and runs the memory read/write handshake. It consumes the datapath's IR contents and the ALU flags, and produces the control signals the datapath has so far received from the testbench.

Parameters:
ACK_TIMEOUT, 16, maximum cycles to wait for mem_ack before entering HALT; 0 disables the timeout.
TW, 5, width of the internal timeout counter; must satisfy 2^TW > ACK_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ir  in  16  IR register output
alu_z  in  1  ALU zero flag, combinational
alu_n  in  1  ALU sign flag, alu_out[15], combinational
mem_ack  in  1  memory completed the current mem_rd/mem_wr
ld_ir, ld_pc, ld_rdir, ld_ra, ld_regb  out  1 each  register load enables
pc_sel  out  2  PC input select: 00 PC+1, 01 ir[7:0] branch target, 10 zero
addr_sel  out  1  memory address select: 0 PC, 1 RDIR
regb_addr_r, regb_addr_w  out  3 each  register bank read and write addresses
operar  out  1  1 = ALU computes; 0 = ALU passes memory data
alu_op  out  2  00 ADD, 01 SUB, 10 ASR, 11 AND
alu_imm  out  1  ALU B operand: 1 sign-extended immediate, 0 register bank
mem_rd, mem_wr  out  1 each  memory request strobes, held until ack
halt  out  1  CPU stopped: illegal opcode or ack timeout

Behaviour:
- Instruction classes by ir[15:14]: 00 LOAD, 01 STORE, 10 BRANCH, 11 ALU.
- Fields: Rd/Rf = ir[13:11]; Ri/Rf1 = ir[10:8]; Rf2 = ir[7:5]; ALU func = ir[2:0]; branch cond = ir[13:11].
- ALU func mapping: 000 ADDI, 001 SUBI, 100 ADD, 101 SUB, 110 ASR, 111 AND. 010 and 011 are illegal and lead to HALT.
- Internal flags Z and N are latched from alu_z/alu_n on every ld_regb, i.e. on ALU and LOAD instructions only. Reset value Z=0, N=0.
- Reset (asynchronous, any state): state=RESET_PC, all outputs 0, Z=N=0, timeout counter 0.
- State RESET_PC: pc_sel=10, ld_pc=1 for one cycle, then FETCH.
- State FETCH: addr_sel=0, mem_rd=1. On mem_ack: ld_ir=1, ld_pc=1, pc_sel=00, then DECODE.
- State DECODE: ld_rdir=1, ld_ra=1, regb_addr_r=ir[10:8]. Next state by class:
  - LOAD goes to LD_MEM.
  - STORE goes to ST_MEM.
  - ALU goes to EXEC, or to HALT if illegal.
  - BRANCH: if taken, ld_pc=1 and pc_sel=01; in all cases next state is FETCH.
- Branch conditions: 000 always, 001 Z, 010 N, 011 N|Z, 101 !Z, 110 !N, 111 !N&!Z. 100 is never taken (NOP).
- State EXEC: operar=1, alu_op and alu_imm decoded from ir[2:0], regb_addr_r=ir[7:5], regb_addr_w=ir[13:11], ld_regb=1, then FETCH.
- State LD_MEM: addr_sel=1, mem_rd=1. On ack: operar=0, regb_addr_w=ir[13:11], ld_regb=1, then FETCH.
- State ST_MEM: addr_sel=1, regb_addr_r=ir[13:11], mem_wr=1. On ack, go to FETCH.
- Memory handshake:
  - mem_rd/mem_wr are asserted from state entry until the cycle mem_ack is sampled high, inclusive.
  - mem_rd and mem_wr are never asserted together.
  - mem_ack seen while no request is pending is ignored.
- Ack timeout: while waiting, the counter increments each cycle. When it reaches ACK_TIMEOUT, the block enters HALT. The counter clears on state exit.
- Latency with zero-wait memory (ack in the request cycle):
  - ALU instruction: 3 cycles.
  - BRANCH: 2 cycles.
  - LOAD and STORE: 3 cycles.
  - Each ack wait adds 1 cycle.
- HALT: halt=1, all other outputs 0. It is left only by reset.

Optional Feature:
MR_CU_SINGLE_STEP_EN: adds input step (1 bit). When defined, FETCH asserts mem_rd only after a step pulse has been seen since the previous instruction completed. A pulse arriving mid-instruction is latched and consumed at the next FETCH. When undefined, FETCH proceeds immediately and the port does not exist.

Decomposition:
- Package mr_pkg holds:
  - state encoding constants;
  - class codes LOAD/STORE/BRANCH/ALU;
  - ALU func codes and alu_op codes;
  - pc_sel codes;
  - branch condition codes.
- One combinational sub-module, mr_branch_eval (inputs cond, Z, N; output taken), owned by the DECODE state.

Test Plan:
- Reset release: 1 cycle with pc_sel=10 and ld_pc=1, then mem_rd=1 and addr_sel=0.
- ir=0xC8E4 (ADD R1,R0,R7 form; func 100), ack immediate: EXEC asserts alu_op=00, alu_imm=0, regb_addr_r=7, regb_addr_w=1, ld_regb=1; next cycle mem_rd=1.
- BEQ with Z=1 after an ALU result of 0: DECODE asserts ld_pc=1 and pc_sel=01. Same instruction with Z=0: pc_sel not 01, ld_pc=0.
- LOAD with mem_ack delayed 3 cycles: mem_rd and addr_sel=1 held 4 cycles, then ld_regb=1 with operar=0.
- STORE with mem_ack never arriving and ACK_TIMEOUT=16: mem_wr high for 16 cycles, then halt=1. Pulsing rst_n low returns the block to RESET_PC.
- ir with func 010: halt=1 immediately after DECODE; rst_n asserted mid-EXEC forces all outputs to 0 asynchronously.
